fifo_mem_ctrl: RTL

Parametrised single-clock FIFO combining the dual-port storage array with pointer management, occupancy counting and status flags. It replaces externally driven read/write pointers: the block owns its pointers and exposes a push/pop interface with full, empty and programmable almost-full/almost-empty thresholds. It sits between the packet-source logic and the downstream arbiter as the main queue of each datapath lane.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram_dp.sv | 39 +++
 rtl/fifo_mem_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and size derivations
package fifo_pkg;

    localparam int FIFO_DATA_SIZE = 10;
    localparam int FIFO_ADDR_SIZE = 3;
    localparam int FIFO_AF_THRESH = 6;
    localparam int FIFO_AE_THRESH = 1;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int fifo_cnt_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - dual-port storage array, sync write, registered read
module fifo_ram_dp import fifo_pkg::*; #(
    parameter int DATA_SIZE = FIFO_DATA_SIZE,
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] rd_data_q;

    // Storage is never cleared; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A same-address write in this cycle is not visible: the old word is read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// rtl/fifo_mem_ctrl.sv - single-clock FIFO with flags; FIFO_ERR_EN adds sticky error flags
module fifo_mem_ctrl import fifo_pkg::*; #(
    parameter int DATA_SIZE = FIFO_DATA_SIZE,
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE,
    parameter int AF_THRESH = FIFO_AF_THRESH,
    parameter int AE_THRESH = FIFO_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
`ifdef FIFO_ERR_EN
    output logic                 err_overflow,
    output logic                 err_underflow,
`endif
    output logic [ADDR_SIZE:0]   fifo_count
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);
    localparam int CNT_W = fifo_cnt_width(ADDR_SIZE);

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 valid_out_q;
    logic                 pop_acc;
    logic                 wr_acc;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_acc = pop && !empty;
    assign wr_acc  = !reset && push && (!full || pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !pop_acc) begin
            count_d = count_q + 1'b1;
        end else if (pop_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_out_q <= pop_acc;
        end
    end

    fifo_ram_dp #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign valid_out    = valid_out_q;
    assign fifo_count   = count_q;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

`ifdef FIFO_ERR_EN
    logic err_overflow_q;
    logic err_underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                err_overflow_q <= 1'b1;
            end
            if (pop && empty) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
`endif

endmodule
